// File: rtl/cla_pkg.sv
// Shared constants, result type, FIFO state encoding and saturation helper
// for the carry-lookahead adder result collector.
package cla_pkg;

  localparam int CLA_WIDTH   = 4;
  localparam int CLA_LATENCY = 5;

  typedef logic [CLA_WIDTH:0] result_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

  // All-ones value of a w-bit unsigned quantity.
  function automatic logic [63:0] sat_max(input int unsigned w);
    sat_max = (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/cla_result_fifo.sv
// Show-ahead result FIFO: head is registered and holds its last value when
// the FIFO drains; push and pop in one cycle are legal even when full.
module cla_result_fifo import cla_pkg::*; #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = $bits(result_t),
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output fifo_state_t           state
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_next;
  logic                  pop_ok;
  logic [CNT_WIDTH-1:0]  occ_next;
  logic [DATA_WIDTH-1:0] head_next;
  fifo_state_t           state_next;

  // Next pointers, occupancy, state and the head entry after this cycle.
  always_comb begin
    pop_ok      = pop & valid;
    rd_ptr_next = rd_ptr + AW'(pop_ok);
    occ_next    = occupancy + CNT_WIDTH'(push) - CNT_WIDTH'(pop_ok);
    // The slot being written is the new head only when nothing older remains.
    if (occ_next == '0) begin
      head_next = head;
    end else if (push && (wr_ptr == rd_ptr_next)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
    case (state)
      FIFO_EMPTY: begin
        state_next = push ? FIFO_PARTIAL : FIFO_EMPTY;
      end
      FIFO_PARTIAL, FIFO_FULL: begin
        if (occ_next == '0) begin
          state_next = FIFO_EMPTY;
        end else if (occ_next == CNT_WIDTH'(DEPTH)) begin
          state_next = FIFO_FULL;
        end else begin
          state_next = FIFO_PARTIAL;
        end
      end
      default: begin
        state_next = FIFO_EMPTY;
      end
    endcase
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, registered head and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      valid     <= 1'b0;
      head      <= '0;
      state     <= FIFO_EMPTY;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr_next;
      occupancy <= occ_next;
      valid     <= (occ_next != '0);
      head      <= head_next;
      state     <= state_next;
    end
  end

endmodule

// File: rtl/cla_result_fifo_chk.sv
// Simulation checker: a capture must never land in a full result FIFO
// unless a pop frees the slot in the same cycle.
module cla_result_fifo_chk import cla_pkg::*; (
  input logic        clk,
  input logic        rst_n,
  input logic        push,
  input logic        pop,
  input fifo_state_t state
);

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (state == FIFO_FULL) && !pop));

endmodule

// File: rtl/cla_result_collector.sv
// Collects pipelined CLA results into a credit-protected FIFO and keeps a
// saturating running sum. Define CLA_COLLECT_STATS_EN to add the o_count port.
module cla_result_collector import cla_pkg::*; #(
  parameter int WIDTH     = CLA_WIDTH,
  parameter int LATENCY   = CLA_LATENCY,
  parameter int DEPTH     = 4,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_issue_valid,
  output logic                 o_issue_ready,
  input  logic [WIDTH:0]       i_result,
  input  logic                 i_clear,
  output logic [WIDTH:0]       o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_acc,
`ifdef CLA_COLLECT_STATS_EN
  output logic [15:0]          o_count,
`endif
  output logic                 o_acc_sat
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));

  logic [LATENCY-1:0]  tag;
  logic                issue_fire;
  logic                capture;
  logic                pop;
  logic [31:0]         inflight;
  logic [CW-1:0]       occupancy;
  fifo_state_t         fifo_state;
  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]  acc_sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                sat_next;

  assign issue_fire = i_issue_valid & o_issue_ready;
  assign capture    = tag[LATENCY-1];
  assign pop        = o_valid & i_ready;

  // Credit: every in-flight tag already owns a FIFO slot.
  always_comb begin
    inflight = 32'd0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + {31'd0, tag[i]};
    end
    o_issue_ready = ((32'(occupancy) + inflight) < 32'(DEPTH));
  end

  // Tag pipe mirroring the adder pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag <= '0;
    end else begin
      tag <= LATENCY'({tag, issue_fire});
    end
  end

  cla_result_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (WIDTH + 1),
    .CNT_WIDTH  (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (i_result),
    .pop       (pop),
    .head      (o_data),
    .valid     (o_valid),
    .occupancy (occupancy),
    .state     (fifo_state)
  );

  cla_result_fifo_chk u_fifo_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .pop   (pop),
    .state (fifo_state)
  );

  // Saturating accumulate; a same-cycle clear is applied before the capture.
  always_comb begin
    acc_base = i_clear ? '0 : o_acc;
    acc_sum  = {1'b0, acc_base} + (ACC_WIDTH + 1)'(i_result);
    if (capture) begin
      if (acc_sum > {1'b0, ACC_MAX}) begin
        acc_next = ACC_MAX;
        sat_next = 1'b1;
      end else begin
        acc_next = acc_sum[ACC_WIDTH-1:0];
        sat_next = i_clear ? 1'b0 : o_acc_sat;
      end
    end else begin
      acc_next = acc_base;
      sat_next = i_clear ? 1'b0 : o_acc_sat;
    end
  end

  // Running sum and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_acc     <= '0;
      o_acc_sat <= 1'b0;
    end else begin
      o_acc     <= acc_next;
      o_acc_sat <= sat_next;
    end
  end

`ifdef CLA_COLLECT_STATS_EN
  logic [15:0] count_base;

  assign count_base = i_clear ? 16'd0 : o_count;

  // Capture counter, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count <= 16'd0;
    end else if (capture) begin
      o_count <= count_base + 16'd1;
    end else begin
      o_count <= count_base;
    end
  end
`endif

endmodule

// File: tb/tb_cla_result_collector.sv
// Directed, table-driven bench for cla_result_collector (accumulator built
// 6 bits wide so saturation is reachable with a few captures).
module tb_cla_result_collector;

  localparam int WIDTH     = 4;
  localparam int LATENCY   = 5;
  localparam int DEPTH     = 4;
  localparam int ACC_WIDTH = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_issue_valid = 1'b0;
  logic                 i_clear = 1'b0;
  logic                 i_ready = 1'b0;
  logic [WIDTH:0]       i_result = '0;
  logic                 o_issue_ready;
  logic                 o_valid;
  logic                 o_acc_sat;
  logic [WIDTH:0]       o_data;
  logic [ACC_WIDTH-1:0] o_acc;
`ifdef CLA_COLLECT_STATS_EN
  logic [15:0]          o_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_result_collector #(
    .WIDTH     (WIDTH),
    .LATENCY   (LATENCY),
    .DEPTH     (DEPTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_issue_valid (i_issue_valid),
    .o_issue_ready (o_issue_ready),
    .i_result      (i_result),
    .i_clear       (i_clear),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_acc         (o_acc),
`ifdef CLA_COLLECT_STATS_EN
    .o_count       (o_count),
`endif
    .o_acc_sat     (o_acc_sat)
  );

  typedef struct {
    logic       iss;
    logic [4:0] res;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [4:0] d;
    logic [5:0] acc;
    logic       sat;
    logic       cr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t row(input logic iss, input logic [4:0] res, input logic rdy,
                               input logic clr, input logic v, input logic [4:0] d,
                               input logic [5:0] acc, input logic sat, input logic cr);
    vec_t r;
    r.iss = iss; r.res = res; r.rdy = rdy; r.clr = clr;
    r.v = v; r.d = d; r.acc = acc; r.sat = sat; r.cr = cr;
    return r;
  endfunction

  initial begin
    // Idle rows drive 5'h03 on the result bus: any untagged capture would show in o_acc.
    vecs.push_back(row(1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 5'h00, 6'd0, 1'b0, 1'b1));
    for (int i = 1; i <= 4; i++) vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h00, 6'd0, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h0B, 1'b1, 1'b0, 1'b1, 5'h0B, 6'd11, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h0B, 6'd11, 1'b0, 1'b1));
    vecs.push_back(row(1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 5'h0B, 6'd11, 1'b0, 1'b1));
    vecs.push_back(row(1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 5'h0B, 6'd11, 1'b0, 1'b1));
    for (int i = 9; i <= 11; i++) vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h0B, 6'd11, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h05, 1'b1, 1'b0, 1'b1, 5'h05, 6'd16, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h02, 1'b1, 1'b0, 1'b1, 5'h02, 6'd18, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h02, 6'd18, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b1, 1'b0, 5'h02, 6'd0, 1'b0, 1'b1));
    for (int i = 16; i <= 18; i++) vecs.push_back(row(1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 5'h02, 6'd0, 1'b0, 1'b1));
    for (int i = 19; i <= 20; i++) vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h02, 6'd0, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h1F, 1'b1, 1'b0, 1'b1, 5'h1F, 6'd31, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h1F, 1'b1, 1'b0, 1'b1, 5'h1F, 6'd62, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h02, 1'b1, 1'b0, 1'b1, 5'h02, 6'd63, 1'b1, 1'b1));
    vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h02, 6'd63, 1'b1, 1'b1));
    vecs.push_back(row(1'b1, 5'h03, 1'b1, 1'b0, 1'b0, 5'h02, 6'd63, 1'b1, 1'b1));
    for (int i = 26; i <= 29; i++) vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h02, 6'd63, 1'b1, 1'b1));
    vecs.push_back(row(1'b0, 5'h07, 1'b1, 1'b1, 1'b1, 5'h07, 6'd7, 1'b0, 1'b1));
    vecs.push_back(row(1'b0, 5'h03, 1'b1, 1'b0, 1'b0, 5'h07, 6'd7, 1'b0, 1'b1));

    // Reset values while held in reset.
    #3;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_acc", 32'(o_acc), 32'd0);
    check("rst_sat", 32'(o_acc_sat), 32'd0);
    check("rst_credit", 32'(o_issue_ready), 32'd1);
`ifdef CLA_COLLECT_STATS_EN
    check("rst_count", 32'(o_count), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[k]) begin
      i_issue_valid = vecs[k].iss;
      i_result      = vecs[k].res;
      i_ready       = vecs[k].rdy;
      i_clear       = vecs[k].clr;
      step();
      check($sformatf("row%0d_valid", k), 32'(o_valid), 32'(vecs[k].v));
      check($sformatf("row%0d_data", k), 32'(o_data), 32'(vecs[k].d));
      check($sformatf("row%0d_acc", k), 32'(o_acc), 32'(vecs[k].acc));
      check($sformatf("row%0d_sat", k), 32'(o_acc_sat), 32'(vecs[k].sat));
      check($sformatf("row%0d_credit", k), 32'(o_issue_ready), 32'(vecs[k].cr));
    end

    // Back-pressure: continuous issue with the consumer stalled.
    i_ready = 1'b0;
    i_issue_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      i_clear  = (k == 0);
      i_result = 5'(k + 10);
      step();
      check($sformatf("bp_credit%0d", k), 32'(o_issue_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    i_clear = 1'b0;
    check("bp_valid", 32'(o_valid), 32'd1);
    check("bp_head", 32'(o_data), 32'd15);
    check("bp_acc", 32'(o_acc), 32'd63);
    check("bp_sat", 32'(o_acc_sat), 32'd1);
    i_issue_valid = 1'b0;
    i_ready = 1'b1;
    i_result = 5'h01;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("drain_data%0d", k), 32'(o_data), 32'(16 + k));
      check($sformatf("drain_valid%0d", k), 32'(o_valid), 32'd1);
      check($sformatf("drain_credit%0d", k), 32'(o_issue_ready), 32'd1);
    end
    step();
    check("drain_empty", 32'(o_valid), 32'd0);
    check("drain_hold", 32'(o_data), 32'd18);

    // Reset with two results buffered and two in flight.
    i_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      i_issue_valid = (k < 2) || (k >= 7);
      i_result = 5'(k + 1);
      step();
    end
    i_issue_valid = 1'b0;
    check("pre_rst_head", 32'(o_data), 32'd6);
    check("pre_rst_credit", 32'(o_issue_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_data", 32'(o_data), 32'd0);
    check("mid_rst_acc", 32'(o_acc), 32'd0);
    check("mid_rst_sat", 32'(o_acc_sat), 32'd0);
    check("mid_rst_credit", 32'(o_issue_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    i_result = 5'h1A;
    repeat (8) step();
    check("post_rst_valid", 32'(o_valid), 32'd0);
    check("post_rst_acc", 32'(o_acc), 32'd0);
    check("post_rst_credit", 32'(o_issue_ready), 32'd1);

`ifdef CLA_COLLECT_STATS_EN
    for (int k = 0; k < 12; k++) begin
      i_issue_valid = (k == 0) || (k == 2) || (k == 4);
      i_result = 5'h01;
      step();
    end
    i_issue_valid = 1'b0;
    check("count_three", 32'(o_count), 32'd3);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    check("count_clear", 32'(o_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
